// File: rtl/dma_host_sequencer.sv
// dma_host_sequencer
// Host-side bus sequencer that replays a loadable script of register writes,
// read-back checks and bus-grant phases against an 8237A-style DMA block.
//
// Ports:
//   clk, rst_n        system clock (rising edge), async active-low reset
//   start             begin script at entry 0 (only in IDLE or DONE)
//   load_we/ptr/op/addr/data  script RAM write port (ignored while busy)
//   data_in, hrq      read data and hold request from the DMA
//   address_bus, data_out, data_oe, iow_n, ior_n   CPU-side bus drive
//   hlda              hold acknowledge
//   busy, done, mismatch, pc   sequencer status
module dma_host_sequencer #(
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 4,
  parameter int DEPTH         = 16,
  parameter int STROBE_CYCLES = 1,
  parameter int HLDA_DELAY    = 2,
  localparam int PTR_W        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              load_we,
  input  logic [PTR_W-1:0]  load_ptr,
  input  logic [1:0]        load_op,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [DATA_W-1:0] data_in,
  input  logic              hrq,
  output logic [ADDR_W-1:0] address_bus,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic              iow_n,
  output logic              ior_n,
  output logic              hlda,
  output logic              busy,
  output logic              done,
  output logic              mismatch,
  output logic [PTR_W-1:0]  pc
);

  localparam int ENT_W   = 2 + ADDR_W + DATA_W;
  localparam int CNT_MAX = (STROBE_CYCLES > HLDA_DELAY) ? STROBE_CYCLES : HLDA_DELAY;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GRANT_LAST  = CNT_W'((HLDA_DELAY > 0) ? (HLDA_DELAY - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [PTR_W-1:0] PC_LAST     = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PC_ONE      = PTR_W'(1);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_GRANT = 2'b10;
  localparam logic [1:0] OP_END   = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_SETUP, S_STROBE, S_RECOVER,
    S_WAIT_HRQ, S_GRANT_DLY, S_GRANTED, S_DONE
  } state_t;

  // Script storage is deliberately not reset so a script survives rst_n.
  logic [ENT_W-1:0] ram_r [DEPTH];

  state_t            state_r, state_s;
  logic [PTR_W-1:0]  pc_r, pc_s;
  logic [1:0]        cmd_op_r, cmd_op_s;
  logic [DATA_W-1:0] cmd_data_r, cmd_data_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [DATA_W-1:0] dout_r, dout_s;
  logic              oe_r, oe_s;
  logic              iow_n_r, iow_n_s;
  logic              ior_n_r, ior_n_s;
  logic              hlda_r, hlda_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              mism_r, mism_s;

  logic [ENT_W-1:0]  fetch_ent_s;
  logic [1:0]        fetch_op_s;
  logic [ADDR_W-1:0] fetch_addr_s;
  logic [DATA_W-1:0] fetch_data_s;

  assign fetch_ent_s  = ram_r[pc_r];
  assign fetch_op_s   = fetch_ent_s[ENT_W-1 -: 2];
  assign fetch_addr_s = fetch_ent_s[DATA_W +: ADDR_W];
  assign fetch_data_s = fetch_ent_s[DATA_W-1:0];

  // Script RAM write port, locked out while a script is running.
  always_ff @(posedge clk) begin
    if (load_we && !busy_r) begin
      ram_r[load_ptr] <= {load_op, load_addr, load_data};
    end
  end

  // Next-state and next-output logic; every output is registered from here.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    cmd_op_s   = cmd_op_r;
    cmd_data_s = cmd_data_r;
    cnt_s      = cnt_r;
    addr_s     = addr_r;
    dout_s     = dout_r;
    oe_s       = oe_r;
    iow_n_s    = 1'b1;
    ior_n_s    = 1'b1;
    hlda_s     = 1'b0;
    mism_s     = mism_r;

    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_s = S_FETCH;
          pc_s    = {PTR_W{1'b0}};
          mism_s  = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      S_FETCH: begin
        cmd_op_s   = fetch_op_s;
        cmd_data_s = fetch_data_s;
        case (fetch_op_s)
          OP_WRITE: begin
            state_s = S_SETUP;
            addr_s  = fetch_addr_s;
            dout_s  = fetch_data_s;
            oe_s    = 1'b1;
          end
          OP_READ: begin
            state_s = S_SETUP;
            addr_s  = fetch_addr_s;
            oe_s    = 1'b0;
          end
          OP_GRANT: begin
            state_s = S_WAIT_HRQ;
            oe_s    = 1'b0;
          end
          OP_END: begin
            state_s = S_DONE;
          end
          default: begin
            state_s = S_DONE;
          end
        endcase
      end
      S_SETUP: begin
        // Address/data were launched a cycle earlier, so the strobe can fall now.
        state_s = S_STROBE;
        cnt_s   = {CNT_W{1'b0}};
        iow_n_s = (cmd_op_r != OP_WRITE);
        ior_n_s = (cmd_op_r != OP_READ);
      end
      S_STROBE: begin
        if (cnt_r == STROBE_LAST) begin
          state_s = S_RECOVER;
          if ((cmd_op_r == OP_READ) && (data_in != cmd_data_r)) begin
            mism_s = 1'b1;
          end else begin
            mism_s = mism_r;
          end
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
          iow_n_s = (cmd_op_r != OP_WRITE);
          ior_n_s = (cmd_op_r != OP_READ);
        end
      end
      S_RECOVER: begin
        if (pc_r == PC_LAST) begin
          state_s = S_DONE;
        end else begin
          state_s = S_FETCH;
          pc_s    = pc_r + PC_ONE;
        end
      end
      S_WAIT_HRQ: begin
        oe_s = 1'b0;
        if (hrq) begin
          if (HLDA_DELAY == 0) begin
            state_s = S_GRANTED;
            hlda_s  = 1'b1;
          end else begin
            state_s = S_GRANT_DLY;
            cnt_s   = {CNT_W{1'b0}};
          end
        end else begin
          state_s = S_WAIT_HRQ;
        end
      end
      S_GRANT_DLY: begin
        // A request withdrawn during the delay is dropped without an hlda pulse.
        if (!hrq) begin
          state_s = S_WAIT_HRQ;
        end else if (cnt_r == GRANT_LAST) begin
          state_s = S_GRANTED;
          hlda_s  = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_GRANTED: begin
        if (hrq) begin
          hlda_s = 1'b1;
        end else if (pc_r == PC_LAST) begin
          state_s = S_DONE;
        end else begin
          state_s = S_FETCH;
          pc_s    = pc_r + PC_ONE;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    busy_s = (state_s != S_IDLE) && (state_s != S_DONE);
    done_s = (state_s == S_DONE);
  end

  // State, command and output registers with asynchronous reset to idle values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      pc_r       <= {PTR_W{1'b0}};
      cmd_op_r   <= 2'b00;
      cmd_data_r <= {DATA_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      addr_r     <= {ADDR_W{1'b0}};
      dout_r     <= {DATA_W{1'b0}};
      oe_r       <= 1'b0;
      iow_n_r    <= 1'b1;
      ior_n_r    <= 1'b1;
      hlda_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      mism_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      cmd_op_r   <= cmd_op_s;
      cmd_data_r <= cmd_data_s;
      cnt_r      <= cnt_s;
      addr_r     <= addr_s;
      dout_r     <= dout_s;
      oe_r       <= oe_s;
      iow_n_r    <= iow_n_s;
      ior_n_r    <= ior_n_s;
      hlda_r     <= hlda_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      mism_r     <= mism_s;
    end
  end

  assign address_bus = addr_r;
  assign data_out    = dout_r;
  assign data_oe     = oe_r;
  assign iow_n       = iow_n_r;
  assign ior_n       = ior_n_r;
  assign hlda        = hlda_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign mismatch    = mism_r;
  assign pc          = pc_r;

endmodule

// File: tb/tb_dma_host_sequencer.sv
// Directed bench for dma_host_sequencer with default parameters
// (DATA_W=8, ADDR_W=4, DEPTH=16, STROBE_CYCLES=1, HLDA_DELAY=2).
// Cycle numbering: the edge that samples start is cycle 0; the values seen
// 1 ns after edge n belong to cycle n+1.
module tb_dma_host_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       load_we;
  logic [3:0] load_ptr;
  logic [1:0] load_op;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic [7:0] data_in;
  logic       hrq;
  logic [3:0] address_bus;
  logic [7:0] data_out;
  logic       data_oe;
  logic       iow_n;
  logic       ior_n;
  logic       hlda;
  logic       busy;
  logic       done;
  logic       mismatch;
  logic [3:0] pc;

  int n_vec  = 0;
  int n_miss = 0;

  dma_host_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_we(load_we),
    .load_ptr(load_ptr), .load_op(load_op), .load_addr(load_addr),
    .load_data(load_data), .data_in(data_in), .hrq(hrq),
    .address_bus(address_bus), .data_out(data_out), .data_oe(data_oe),
    .iow_n(iow_n), .ior_n(ior_n), .hlda(hlda), .busy(busy), .done(done),
    .mismatch(mismatch), .pc(pc)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_entry(input int ptr, input logic [1:0] op, input logic [3:0] addr,
                            input logic [7:0] data);
    load_we   = 1'b1;
    load_ptr  = ptr[3:0];
    load_op   = op;
    load_addr = addr;
    load_data = data;
    tick();
    load_we   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while ((done !== 1'b1) && (k < 200)) begin
      tick();
      k++;
    end
    check_val({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  logic [3:0] wb_addr [3];
  logic [7:0] wb_data [3];
  int         npulse;

  initial begin
    wb_addr = '{4'h0, 4'h8, 4'hB};
    wb_data = '{8'h12, 8'h34, 8'h56};
    rst_n = 1'b0; start = 1'b0; load_we = 1'b0; load_ptr = 4'h0; load_op = 2'b00;
    load_addr = 4'h0; load_data = 8'h00; data_in = 8'h00; hrq = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_addr", {28'd0, address_bus}, 32'd0);
    check_val("rst_dout", {24'd0, data_out}, 32'd0);
    check_val("rst_oe", {31'd0, data_oe}, 32'd0);
    check_val("rst_iow", {31'd0, iow_n}, 32'd1);
    check_val("rst_ior", {31'd0, ior_n}, 32'd1);
    check_val("rst_hlda", {31'd0, hlda}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_mism", {31'd0, mismatch}, 32'd0);
    check_val("rst_pc", {28'd0, pc}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Write burst: three WRITEs then END
    for (int i = 0; i < 3; i++) load_entry(i, 2'b00, wb_addr[i], wb_data[i]);
    load_entry(3, 2'b11, 4'h0, 8'h00);
    pulse_start();
    for (int c = 1; c <= 14; c++) begin
      check_val($sformatf("wb_iow_c%0d", c), {31'd0, iow_n},
                (c == 3 || c == 7 || c == 11) ? 32'd0 : 32'd1);
      check_val($sformatf("wb_ior_c%0d", c), {31'd0, ior_n}, 32'd1);
      check_val($sformatf("wb_done_c%0d", c), {31'd0, done}, (c == 14) ? 32'd1 : 32'd0);
      check_val($sformatf("wb_busy_c%0d", c), {31'd0, busy}, (c == 14) ? 32'd0 : 32'd1);
      if (c >= 2 && c <= 12 && ((c - 2) % 4) <= 2) begin
        check_val($sformatf("wb_addr_c%0d", c), {28'd0, address_bus}, {28'd0, wb_addr[(c - 2) / 4]});
        check_val($sformatf("wb_data_c%0d", c), {24'd0, data_out}, {24'd0, wb_data[(c - 2) / 4]});
        check_val($sformatf("wb_oe_c%0d", c), {31'd0, data_oe}, 32'd1);
      end
      if (c < 14) tick();
    end

    // Reset asserted mid-STROBE, then script rerun from retained RAM
    pulse_start();
    tick();
    tick();
    check_val("mr_iow_pre", {31'd0, iow_n}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_val("mr_iow", {31'd0, iow_n}, 32'd1);
    check_val("mr_busy", {31'd0, busy}, 32'd0);
    check_val("mr_addr", {28'd0, address_bus}, 32'd0);
    check_val("mr_dout", {24'd0, data_out}, 32'd0);
    check_val("mr_oe", {31'd0, data_oe}, 32'd0);
    check_val("mr_pc", {28'd0, pc}, 32'd0);
    tick();
    check_val("mr_iow_hold", {31'd0, iow_n}, 32'd1);
    rst_n = 1'b1;
    tick();
    check_val("mr_idle_busy", {31'd0, busy}, 32'd0);
    check_val("mr_idle_done", {31'd0, done}, 32'd0);
    pulse_start();
    check_val("mr_fetch_busy", {31'd0, busy}, 32'd1);
    tick();
    tick();
    check_val("mr_rerun_iow", {31'd0, iow_n}, 32'd0);
    check_val("mr_rerun_addr", {28'd0, address_bus}, 32'd0);
    check_val("mr_rerun_data", {24'd0, data_out}, 32'h12);
    wait_done("mr");

    // Read compare: matching, then mismatching, then cleared by start
    load_entry(0, 2'b01, 4'h8, 8'hA5);
    load_entry(1, 2'b11, 4'h0, 8'h00);
    data_in = 8'hA5;
    pulse_start();
    tick();
    tick();
    check_val("rd_ior", {31'd0, ior_n}, 32'd0);
    check_val("rd_iow", {31'd0, iow_n}, 32'd1);
    check_val("rd_addr", {28'd0, address_bus}, 32'h8);
    check_val("rd_oe", {31'd0, data_oe}, 32'd0);
    wait_done("rd_ok");
    check_val("rd_ok_mism", {31'd0, mismatch}, 32'd0);
    data_in = 8'h5A;
    pulse_start();
    tick();
    tick();
    tick();
    check_val("rd_bad_mism_c4", {31'd0, mismatch}, 32'd1);
    wait_done("rd_bad");
    check_val("rd_bad_mism_done", {31'd0, mismatch}, 32'd1);
    data_in = 8'hA5;
    pulse_start();
    check_val("rd_clr_mism", {31'd0, mismatch}, 32'd0);
    check_val("rd_clr_done", {31'd0, done}, 32'd0);
    wait_done("rd_clr");
    check_val("rd_clr_mism_end", {31'd0, mismatch}, 32'd0);

    // Grant handshake followed by a WRITE
    load_entry(0, 2'b10, 4'h0, 8'h00);
    load_entry(1, 2'b00, 4'h3, 8'h77);
    load_entry(2, 2'b11, 4'h0, 8'h00);
    pulse_start();
    for (int c = 1; c <= 14; c++) begin
      check_val($sformatf("gr_hlda_c%0d", c), {31'd0, hlda},
                (c >= 8 && c <= 11) ? 32'd1 : 32'd0);
      if (c >= 2 && c <= 11) begin
        check_val($sformatf("gr_oe_c%0d", c), {31'd0, data_oe}, 32'd0);
        check_val($sformatf("gr_iow_c%0d", c), {31'd0, iow_n}, 32'd1);
      end
      if (c == 14) begin
        check_val("gr_next_iow", {31'd0, iow_n}, 32'd0);
        check_val("gr_next_addr", {28'd0, address_bus}, 32'h3);
        check_val("gr_next_data", {24'd0, data_out}, 32'h77);
      end
      hrq = (c >= 5 && c <= 10);
      if (c < 14) tick();
    end
    hrq = 1'b0;
    wait_done("gr");

    // Grant abort during the HLDA delay, then a normal grant
    load_entry(1, 2'b11, 4'h0, 8'h00);
    pulse_start();
    for (int c = 1; c <= 17; c++) begin
      check_val($sformatf("ab_hlda_c%0d", c), {31'd0, hlda},
                (c >= 13 && c <= 15) ? 32'd1 : 32'd0);
      check_val($sformatf("ab_done_c%0d", c), {31'd0, done}, (c == 17) ? 32'd1 : 32'd0);
      hrq = (c == 5) || (c >= 10 && c <= 14);
      if (c < 17) tick();
    end
    hrq = 1'b0;

    // All 16 entries WRITE, no END; load_we and start mid-script are ignored
    for (int i = 0; i < 16; i++) load_entry(i, 2'b00, i[3:0], 8'h10 + i[7:0]);
    pulse_start();
    npulse = 0;
    for (int c = 1; c <= 65; c++) begin
      if (iow_n === 1'b0) npulse++;
      if (c >= 3 && c <= 63 && ((c - 3) % 4) == 0) begin
        check_val($sformatf("em_iow_c%0d", c), {31'd0, iow_n}, 32'd0);
        check_val($sformatf("em_addr_c%0d", c), {28'd0, address_bus}, (c - 3) / 4);
        check_val($sformatf("em_data_c%0d", c), {24'd0, data_out}, 32'h10 + (c - 3) / 4);
      end
      check_val($sformatf("em_done_c%0d", c), {31'd0, done}, (c == 65) ? 32'd1 : 32'd0);
      if (c == 10) begin
        load_we = 1'b1; load_ptr = 4'h3; load_op = 2'b11; load_addr = 4'h0; load_data = 8'h00;
        start = 1'b1;
      end else begin
        load_we = 1'b0;
        start = 1'b0;
      end
      if (c < 65) tick();
    end
    check_val("em_pc", {28'd0, pc}, 32'd15);
    check_val("em_pulses", npulse, 32'd16);
    check_val("em_busy", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
